// File: rtl/pipeline_if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package pipeline_if_stage_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        DRAIN   = 2'd2
    } if_state_e;
endpackage

// File: rtl/pipeline_if_id_reg.sv
// IF/ID pipeline register: flush beats load beats hold; flush and reset give {0, NOP, 0}.
module pipeline_if_id_reg
    import pipeline_if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            load,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] inst_d,
    output logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] inst_q,
    output logic            valid_q
);
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
        end else if (load) begin
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= 1'b1;
        end
    end
endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction fetch: PC, imem valid/ready handshake, stall skid buffer and
// redirect drain, feeding the IF/ID register.
module pipeline_if_stage
    import pipeline_if_stage_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCSrc_in_IF,
    input  logic [XLEN-1:0] target_in_IF,
    input  logic            stall_in_IF,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_ready,
    output logic [XLEN-1:0] PC_out_IF,
    output logic [XLEN-1:0] Inst_out_IF,
    output logic            valid_out_IF
);
    if_state_e       state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] buf_pc, buf_pc_d, buf_inst, buf_inst_d;
    logic [XLEN-1:0] redir, redir_d;
    logic [XLEN-1:0] tgt;
    logic            ifid_load, ifid_flush;
    logic [XLEN-1:0] ifid_pc, ifid_inst;

    assign tgt = target_in_IF & ~32'h3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            buf_pc   <= '0;
            buf_inst <= '0;
            redir    <= '0;
        end else begin
            state    <= state_d;
            pc       <= pc_d;
            buf_pc   <= buf_pc_d;
            buf_inst <= buf_inst_d;
            redir    <= redir_d;
        end
    end

    always_comb begin
        state_d    = state;
        pc_d       = pc;
        buf_pc_d   = buf_pc;
        buf_inst_d = buf_inst;
        redir_d    = redir;
        imem_req   = 1'b0;
        imem_addr  = pc;
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_pc    = pc;
        ifid_inst  = imem_rdata;
        unique case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (PCSrc_in_IF) begin
                    ifid_flush = 1'b1;
                    if (imem_ready) begin
                        pc_d = tgt;
                    end else begin
                        // Request can't be withdrawn: keep pc as the address, park the target.
                        redir_d = tgt;
                        state_d = DRAIN;
                    end
                end else if (imem_ready) begin
                    pc_d = pc + 32'd4;
                    if (stall_in_IF) begin
                        buf_pc_d   = pc;
                        buf_inst_d = imem_rdata;
                        state_d    = STALLED;
                    end else begin
                        ifid_load = 1'b1;
                    end
                end else if (!stall_in_IF) begin
                    ifid_flush = 1'b1;
                end
            end
            STALLED: begin
                if (PCSrc_in_IF) begin
                    pc_d       = tgt;
                    ifid_flush = 1'b1;
                    state_d    = FETCH;
                end else if (!stall_in_IF) begin
                    ifid_load = 1'b1;
                    ifid_pc   = buf_pc;
                    ifid_inst = buf_inst;
                    state_d   = FETCH;
                end
            end
            DRAIN: begin
                imem_req   = 1'b1;
                ifid_flush = 1'b1;
                if (PCSrc_in_IF) redir_d = tgt;
                if (imem_ready) begin
                    pc_d    = PCSrc_in_IF ? tgt : redir;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    pipeline_if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (ifid_flush),
        .load    (ifid_load),
        .pc_d    (ifid_pc),
        .inst_d  (ifid_inst),
        .pc_q    (PC_out_IF),
        .inst_q  (Inst_out_IF),
        .valid_q (valid_out_IF)
    );
endmodule

// File: tb/tb_pipeline_if_stage.sv
// Directed table-driven bench for pipeline_if_stage; memory returns 0xA0000000|addr.
module tb_pipeline_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcsrc = 1'b0;
    logic [31:0] target = '0;
    logic        stall = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic [31:0] rdata = '0;
    logic        ready = 1'b0;
    logic [31:0] pc_o, inst_o;
    logic        valid_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipeline_if_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PCSrc_in_IF  (pcsrc),
        .target_in_IF (target),
        .stall_in_IF  (stall),
        .imem_req     (req),
        .imem_addr    (addr),
        .imem_rdata   (rdata),
        .imem_ready   (ready),
        .PC_out_IF    (pc_o),
        .Inst_out_IF  (inst_o),
        .valid_out_IF (valid_o)
    );

    typedef struct {
        logic        src;
        logic [31:0] tgt;
        logic        stl;
        logic        rdy;
        logic        ereq;
        logic        chka;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    vec_t vt[24];

    function automatic vec_t mk(logic src, logic [31:0] tgt, logic stl, logic rdy,
                                logic ereq, logic [31:0] eaddr, logic ev, logic [31:0] epc);
        vec_t v;
        v.src = src; v.tgt = tgt; v.stl = stl; v.rdy = rdy;
        v.ereq = ereq; v.chka = ereq; v.eaddr = eaddr;
        v.ev = ev; v.epc = epc;
        v.einst = ev ? (32'hA000_0000 | epc) : NOP;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle: drive, check combinational request, clock, check IF/ID.
    task automatic step(input vec_t v, input int idx);
        pcsrc  = v.src;
        target = v.tgt;
        stall  = v.stl;
        ready  = v.rdy;
        rdata  = v.rdy ? (32'hA000_0000 | v.eaddr) : 32'hBAD0_0000;
        #1;
        chk($sformatf("v%0d req", idx), {31'b0, req}, {31'b0, v.ereq});
        if (v.chka) chk($sformatf("v%0d addr", idx), addr, v.eaddr);
        @(posedge clk);
        #1;
        chk($sformatf("v%0d valid", idx), {31'b0, valid_o}, {31'b0, v.ev});
        chk($sformatf("v%0d pc", idx), pc_o, v.epc);
        chk($sformatf("v%0d inst", idx), inst_o, v.einst);
    endtask

    initial begin
        //              src tgt            stl rdy ereq eaddr          ev epc
        vt[0]  = mk(0, 0,             0, 1, 1, 32'h0,        1, 32'h0);
        vt[1]  = mk(0, 0,             0, 1, 1, 32'h4,        1, 32'h4);
        vt[2]  = mk(0, 0,             0, 0, 1, 32'h8,        0, 32'h0);
        vt[3]  = mk(0, 0,             0, 0, 1, 32'h8,        0, 32'h0);
        vt[4]  = mk(0, 0,             0, 0, 1, 32'h8,        0, 32'h0);
        vt[5]  = mk(0, 0,             0, 1, 1, 32'h8,        1, 32'h8);
        vt[6]  = mk(0, 0,             1, 1, 1, 32'hC,        1, 32'h8);
        vt[7]  = mk(0, 0,             1, 1, 0, 32'h0,        1, 32'h8);
        vt[8]  = mk(0, 0,             0, 1, 0, 32'h0,        1, 32'hC);
        vt[9]  = mk(1, 32'h100,       0, 1, 1, 32'h10,       0, 32'h0);
        vt[10] = mk(0, 0,             0, 1, 1, 32'h100,      1, 32'h100);
        vt[11] = mk(1, 32'h20,        0, 1, 1, 32'h104,      0, 32'h0);
        vt[12] = mk(1, 32'h300,       0, 0, 1, 32'h20,       0, 32'h0);
        vt[13] = mk(1, 32'h200,       0, 0, 1, 32'h20,       0, 32'h0);
        vt[14] = mk(0, 0,             0, 1, 1, 32'h20,       0, 32'h0);
        vt[15] = mk(0, 0,             0, 1, 1, 32'h200,      1, 32'h200);
        vt[16] = mk(0, 0,             1, 1, 1, 32'h204,      1, 32'h200);
        vt[17] = mk(1, 32'h43,        1, 1, 0, 32'h0,        0, 32'h0);
        vt[18] = mk(0, 0,             1, 0, 1, 32'h40,       0, 32'h0);
        vt[19] = mk(0, 0,             0, 1, 1, 32'h40,       1, 32'h40);
        vt[20] = mk(1, 32'hFFFF_FFF8, 0, 1, 1, 32'h44,       0, 32'h0);
        vt[21] = mk(0, 0,             0, 1, 1, 32'hFFFF_FFF8, 1, 32'hFFFF_FFF8);
        vt[22] = mk(0, 0,             0, 1, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC);
        vt[23] = mk(0, 0,             0, 1, 1, 32'h0,        1, 32'h0);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst req", {31'b0, req}, 32'd1);
        chk("rst addr", addr, 32'h0);
        chk("rst valid", {31'b0, valid_o}, 32'd0);
        chk("rst pc", pc_o, 32'h0);
        chk("rst inst", inst_o, NOP);
        @(posedge clk);
        #1;
        // The reset-release cycle had ready=0: one bubble, pc still 0.
        chk("rst bubble valid", {31'b0, valid_o}, 32'd0);

        for (int i = 0; i < 24; i++) step(vt[i], i);

        // Reset in the middle of DRAIN abandons the killed request and the parked target.
        step(mk(1, 32'h80, 0, 0, 1, 32'h4, 0, 32'h0), 100);
        rst_n = 1'b0;
        ready = 1'b0;
        pcsrc = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("drain-rst req", {31'b0, req}, 32'd1);
        chk("drain-rst addr", addr, 32'h0);
        chk("drain-rst valid", {31'b0, valid_o}, 32'd0);
        chk("drain-rst inst", inst_o, NOP);
        step(mk(0, 0, 0, 1, 1, 32'h0, 1, 32'h0), 101);
        step(mk(0, 0, 0, 1, 1, 32'h4, 1, 32'h4), 102);

        // Redirect arriving in DRAIN in the same cycle as ready: newest target wins.
        step(mk(1, 32'h500, 0, 0, 1, 32'h8, 0, 32'h0), 103);
        step(mk(1, 32'h600, 0, 1, 1, 32'h8, 0, 32'h0), 104);
        step(mk(0, 0, 0, 1, 1, 32'h600, 1, 32'h600), 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
